// File: rtl/saturating_pkg.sv
// saturating_pkg: shared state encoding, default width and __output field offsets for saturating_drain
package saturating_pkg;
  localparam int SAT_WIDTH = 8;
  typedef enum logic [1:0] {EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2} sat_state_e;
  // field offsets above the WIDTH-bit tokens field of __output
  localparam int OUT_CLIP_OFS = 0;
  localparam int OUT_ACC_OFS = 1;
  localparam int OUT_RDY_OFS = 2;
  localparam int OUT_STATE_OFS = 3;
endpackage

// File: rtl/sat_clamp.sv
// sat_clamp: floors a two's-complement WIDTH+1 value at 0, adds a refill, then clamps to max and flags any saturation
module sat_clamp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   val_i,
  input  logic [WIDTH-1:0] add_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] res_o,
  output logic             clip_o
);
  logic [WIDTH-1:0] floored;
  logic [WIDTH:0] sum;
  logic over;
  assign floored = val_i[WIDTH] ? '0 : val_i[WIDTH-1:0];
  assign sum = {1'b0, floored} + {1'b0, add_i};
  assign over = sum > {1'b0, max_i};
  assign res_o = over ? max_i : sum[WIDTH-1:0];
  assign clip_o = val_i[WIDTH] | over;
endmodule

// File: rtl/saturating_drain.sv
// saturating_drain: token count drained by valid/ready requests and refilled up to a runtime max.
// SATURATING_DRAIN_PARTIAL_EN: always ready; oversized requests drain the count to 0.
module saturating_drain
  import saturating_pkg::*;
#(
  parameter int WIDTH = SAT_WIDTH
) (
  input  logic             _i_clk,
  input  logic             _i_rst,
  input  logic [WIDTH-1:0] _i_max,
  input  logic             _i_refill_valid,
  input  logic [WIDTH-1:0] _i_refill_amount,
  input  logic             _i_req_valid,
  input  logic [WIDTH-1:0] _i_req_cost,
  output logic [WIDTH+4:0] __output
);
  logic [WIDTH-1:0] tokens_q, tokens_d;
  logic accepted_q, clipped_q, clipped_d, req_ready, fire;
  logic [WIDTH:0] drained;
  sat_state_e state_q, state_d;
`ifdef SATURATING_DRAIN_PARTIAL_EN
  assign req_ready = 1'b1;
`else
  assign req_ready = tokens_q >= _i_req_cost;
`endif
  assign fire = _i_req_valid & req_ready;
  // borrow bit marks an overdrawn count; the clamp floors it before adding the refill
  assign drained = {1'b0, tokens_q} - {1'b0, fire ? _i_req_cost : {WIDTH{1'b0}}};
  sat_clamp #(.WIDTH(WIDTH)) u_clamp (
    .val_i (drained),
    .add_i (_i_refill_valid ? _i_refill_amount : {WIDTH{1'b0}}),
    .max_i (_i_max),
    .res_o (tokens_d),
    .clip_o(clipped_d)
  );
  assign state_d = (tokens_d == _i_max) ? FULL : (tokens_d == '0) ? EMPTY : PARTIAL;
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      tokens_q   <= '0;
      accepted_q <= 1'b0;
      clipped_q  <= 1'b0;
      state_q    <= (_i_max == '0) ? FULL : EMPTY;
    end else begin
      tokens_q   <= tokens_d;
      accepted_q <= fire;
      clipped_q  <= clipped_d;
      state_q    <= state_d;
    end
  end
  assign __output[WIDTH-1:0] = tokens_q;
  assign __output[WIDTH+OUT_CLIP_OFS] = clipped_q;
  assign __output[WIDTH+OUT_ACC_OFS] = accepted_q;
  assign __output[WIDTH+OUT_RDY_OFS] = req_ready;
  assign __output[WIDTH+OUT_STATE_OFS +: 2] = state_q;
endmodule

// File: tb/tb_saturating_drain.sv
// tb_saturating_drain: directed plan checks plus randomized run against an integer reference model
module tb_saturating_drain;
  import saturating_pkg::*;
  localparam int W = 8;
`ifdef SATURATING_DRAIN_PARTIAL_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif
  logic clk = 0, rst = 0, rv = 0, qv = 0;
  logic [W-1:0] mx = '0, amt = '0, cost = '0;
  logic [W+4:0] out;
  int passed = 0, total = 0;
  int m_tok = 0, m_acc = 0, m_clip = 0, m_st = 0;
  saturating_drain #(.WIDTH(W)) dut (
    ._i_clk(clk), ._i_rst(rst), ._i_max(mx), ._i_refill_valid(rv),
    ._i_refill_amount(amt), ._i_req_valid(qv), ._i_req_cost(cost), .__output(out)
  );
  always #5 clk = ~clk;
  function automatic bit m_ready();
    return P || (m_tok >= int'(cost));
  endfunction
  function automatic logic [W+4:0] exp_out();
    return {2'(m_st), m_ready(), m_acc != 0, m_clip != 0, W'(m_tok)};
  endfunction
  task automatic drive(bit r, bit v, int a, bit q, int c);
    rst = r; rv = v; amt = W'(a); qv = q; cost = W'(c);
  endtask
  task automatic tick();
    int mi, t;
    bit f, fl, ov;
    mi = int'(mx);
    if (rst) begin
      m_tok = 0; m_acc = 0; m_clip = 0; m_st = (mi == 0) ? 2 : 0;
    end else begin
      f = qv && m_ready();
      t = m_tok - (f ? int'(cost) : 0);
      fl = t < 0;
      if (fl) t = 0;
      t += rv ? int'(amt) : 0;
      ov = t > mi;
      if (ov) t = mi;
      m_tok = t; m_acc = int'(f); m_clip = int'(fl || ov);
      m_st = (t == mi) ? 2 : (t == 0) ? 0 : 1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    mx = 8'd5; drive(1, 0, 0, 0, 0); tick();
    total++; if (out !== {2'd0, 1'b1, 1'b0, 1'b0, 8'd0}) $display("FAIL reset out=%h exp=%h", out, {2'd0, 1'b1, 1'b0, 1'b0, 8'd0}); else passed++;
  endtask
  task automatic test_refill();
    drive(0, 1, 3, 0, 0); tick();
    total++; if (out !== {2'd1, 1'b1, 1'b0, 1'b0, 8'd3}) $display("FAIL refill3 out=%h exp=%h", out, {2'd1, 1'b1, 1'b0, 1'b0, 8'd3}); else passed++;
    drive(0, 1, 4, 0, 0); tick();
    total++; if (out !== {2'd2, 1'b1, 1'b0, 1'b1, 8'd5}) $display("FAIL refill_clamp out=%h exp=%h", out, {2'd2, 1'b1, 1'b0, 1'b1, 8'd5}); else passed++;
  endtask
  task automatic test_drain();
    drive(0, 0, 0, 1, 2); #1;
    total++; if (out[W+OUT_RDY_OFS] !== 1'b1) $display("FAIL ready_cost2 out=%b exp=1", out[W+OUT_RDY_OFS]); else passed++;
    tick();
    total++; if (out !== {2'd1, 1'b1, 1'b1, 1'b0, 8'd3}) $display("FAIL drain2 out=%h exp=%h", out, {2'd1, 1'b1, 1'b1, 1'b0, 8'd3}); else passed++;
    drive(0, 1, 2, 1, 3); tick();
    total++; if (out !== {2'd1, P, 1'b1, 1'b0, 8'd2}) $display("FAIL drain_refill out=%h exp=%h", out, {2'd1, P, 1'b1, 1'b0, 8'd2}); else passed++;
  endtask
  task automatic test_oversize();
    drive(0, 0, 0, 1, 4);
`ifdef SATURATING_DRAIN_PARTIAL_EN
    tick();
    total++; if (out !== {2'd0, 1'b1, 1'b1, 1'b1, 8'd0}) $display("FAIL partial_fire out=%h exp=%h", out, {2'd0, 1'b1, 1'b1, 1'b1, 8'd0}); else passed++;
`else
    #1;
    total++; if (out[W+OUT_RDY_OFS] !== 1'b0) $display("FAIL stall_ready out=%b exp=0", out[W+OUT_RDY_OFS]); else passed++;
    tick();
    total++; if (out !== {2'd1, 1'b0, 1'b0, 1'b0, 8'd2}) $display("FAIL stall_hold out=%h exp=%h", out, {2'd1, 1'b0, 1'b0, 1'b0, 8'd2}); else passed++;
    drive(0, 1, 2, 1, 4); tick();
    total++; if (out !== {2'd1, 1'b1, 1'b0, 1'b0, 8'd4}) $display("FAIL stall_refill out=%h exp=%h", out, {2'd1, 1'b1, 1'b0, 1'b0, 8'd4}); else passed++;
    drive(0, 0, 0, 1, 4); tick();
    total++; if (out !== {2'd0, 1'b0, 1'b1, 1'b0, 8'd0}) $display("FAIL stall_fire out=%h exp=%h", out, {2'd0, 1'b0, 1'b1, 1'b0, 8'd0}); else passed++;
`endif
  endtask
  task automatic test_max_change();
    drive(0, 1, 5, 0, 0); tick();
    total++; if (out !== {2'd2, 1'b1, 1'b0, 1'b0, 8'd5}) $display("FAIL fill_exact out=%h exp=%h", out, {2'd2, 1'b1, 1'b0, 1'b0, 8'd5}); else passed++;
    mx = 8'd2; drive(0, 0, 0, 0, 0); tick();
    total++; if (out !== {2'd2, 1'b1, 1'b0, 1'b1, 8'd2}) $display("FAIL max_lower out=%h exp=%h", out, {2'd2, 1'b1, 1'b0, 1'b1, 8'd2}); else passed++;
    drive(0, 0, 0, 1, 0); tick();
    total++; if (out !== {2'd2, 1'b1, 1'b1, 1'b0, 8'd2}) $display("FAIL cost_zero out=%h exp=%h", out, {2'd2, 1'b1, 1'b1, 1'b0, 8'd2}); else passed++;
  endtask
  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 1); tick();
    total++; if (out !== {2'd0, P, 1'b0, 1'b0, 8'd0}) $display("FAIL rst_req out=%h exp=%h", out, {2'd0, P, 1'b0, 1'b0, 8'd0}); else passed++;
    drive(0, 0, 0, 0, 1); tick();
    total++; if (out !== {2'd0, P, 1'b0, 1'b0, 8'd0}) $display("FAIL rst_no_acc out=%h exp=%h", out, {2'd0, P, 1'b0, 1'b0, 8'd0}); else passed++;
    mx = 8'd0; drive(1, 0, 0, 0, 0); tick();
    total++; if (out !== {2'd2, 1'b1, 1'b0, 1'b0, 8'd0}) $display("FAIL rst_max0 out=%h exp=%h", out, {2'd2, 1'b1, 1'b0, 1'b0, 8'd0}); else passed++;
    drive(0, 1, 3, 0, 0); tick();
    total++; if (out !== {2'd2, 1'b1, 1'b0, 1'b1, 8'd0}) $display("FAIL max0_refill out=%h exp=%h", out, {2'd2, 1'b1, 1'b0, 1'b1, 8'd0}); else passed++;
    mx = 8'd6; drive(0, 0, 0, 0, 0); tick();
  endtask
  task automatic test_random();
    bit hold;
    for (int i = 0; i < 600; i++) begin
      hold = qv && !m_ready();
      if ($urandom_range(0, 9) == 0) mx = W'($urandom_range(0, 12));
      rst = $urandom_range(0, 49) == 0;
      rv = $urandom_range(0, 1) == 1;
      amt = W'($urandom_range(0, 8));
      if (!hold) begin
        qv = $urandom_range(0, 2) != 0;
        cost = W'($urandom_range(0, 8));
      end
      tick();
      total++; if (out !== exp_out()) $display("FAIL random[%0d] out=%h exp=%h", i, out, exp_out()); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_refill();
    test_drain();
    test_oversize();
    test_max_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/saturating_drain.md
# saturating_drain

Sequential counterpart of the saturating adder: holds a token count that is drained by requests with saturation at zero and refilled with saturation at a runtime ceiling (`max`). It sits between a credit producer (refill side) and a request consumer (drain side), and grants a request only when enough tokens remain. All state is registered on one clock; the request handshake is valid/ready.

## Interface
Parameters:
- `WIDTH`, default 8: width of token count, cost, refill amount and `max`.

Ports:
- `_i_clk`  in  1  clock; all state updates on the rising edge.
- `_i_rst`  in  1  reset, synchronous, active-high.
- `_i_max`  in  WIDTH  saturation ceiling for the token count; may change at any cycle.
- `_i_refill_valid`  in  1  add `_i_refill_amount` this cycle.
- `_i_refill_amount`  in  WIDTH  tokens to add.
- `_i_req_valid`  in  1  drain request present.
- `_i_req_cost`  in  WIDTH  tokens the request consumes; must be held stable while valid and not ready.
- `__output`  out  WIDTH+5  packed, MSB first: `{state[1:0], req_ready, accepted, clipped, tokens[WIDTH-1:0]}`.

## Operation
- `tokens` is a registered count, always 0..`_i_max` after any clock edge.
- `req_ready` is combinational: `tokens >= _i_req_cost`, or constant 1 with the partial feature (see Configuration).
- Handshake: a request fires when `_i_req_valid && req_ready` in the same cycle. There is no queue and at most one fire per cycle.
- Next count, computed at WIDTH+1 bits: `t = tokens - (fire ? cost : 0)`, floored at 0; then `t += refill_valid ? amount : 0`; then `tokens_next = min(t, _i_max)`.
- Simultaneous refill and fire: the drain is applied first, then the refill, then the clamp. Refill tokens never fund the same-cycle request.
- `_i_max` lowered below the current `tokens`: the count clamps to the new `max` on the next edge, even with no refill or request.
- `accepted` is a registered one-cycle pulse, high in the cycle after a fire.
- `clipped` is a registered one-cycle pulse, high when the previous update hit either saturation bound: the `max` clamp reduced the value, or the floor at 0 was applied.
- `state` is registered and derived from `tokens_next`:
  - EMPTY=0 when `tokens_next` = 0.
  - PARTIAL=1 when 0 < `tokens_next` < `max`.
  - FULL=2 when `tokens_next` = `max`.
  - Encoding 3 is unused.
  - When `max` = 0, the state is FULL, since the FULL check takes priority over EMPTY.
- Reset: `tokens`=0, `accepted`=0, `clipped`=0, `state`=EMPTY, or FULL if `_i_max`=0 during reset. `req_ready` follows its combinational rule.
- Reset asserted mid-operation overrides fire and refill in that cycle. `accepted` is not raised for a request present during reset.

## Timing
- Latency from a fire or refill to the new `tokens`/`state`: 1 cycle.
- `req_ready` reflects the current registered count with 0-cycle latency.
- Sustained single-cycle grants are possible while `tokens >= cost` holds each cycle.
- A cost of 0 always fires when valid and leaves the count unchanged apart from the refill and clamp.

## Configuration
- `SATURATING_DRAIN_PARTIAL_EN` undefined: requests stall (`req_ready`=0) until `tokens >= cost`. The floor at 0 is never reached by a drain, so `clipped` is caused only by the `max` clamp.
- `SATURATING_DRAIN_PARTIAL_EN` defined:
  - `req_ready` is tied to 1.
  - A request with `cost > tokens` fires, and the count saturates to 0 (plus any same-cycle refill).
  - `clipped` pulses the next cycle.

## Structure
- Shared package `saturating_pkg`:
  - state enum (EMPTY/PARTIAL/FULL).
  - `SAT_WIDTH`=8 default.
  - output bit-position constants for the `__output` packing.
- One sub-module, `sat_clamp`: a combinational WIDTH+1 → WIDTH unit applying the floor at 0 and the `min` with `max`, and reporting whether it clipped. It is reusable by the saturating adder.

## Test plan
- Reset with `max`=5 → `tokens`=0, `state`=EMPTY, `accepted`=0. Then refill 3 → next cycle `tokens`=3, `state`=PARTIAL, `clipped`=0.
- `tokens`=3, `max`=5, refill 4 → `tokens`=5, `state`=FULL, `clipped`=1 for one cycle.
- `tokens`=5, request cost 2 → `req_ready`=1, next cycle `tokens`=3, `accepted`=1. Same-cycle request cost 3 and refill 2 from `tokens`=3 → `tokens`=2.
- `tokens`=2, request cost 4 (macro off) → `req_ready`=0, count held at 2. Refill 2 → next cycle `req_ready`=1, fire, then `tokens`=0, `state`=EMPTY.
- Macro on: `tokens`=2, request cost 4 → fires, next cycle `tokens`=0, `accepted`=1, `clipped`=1.
- `tokens`=5 with `max` lowered to 2 mid-run → next cycle `tokens`=2, `state`=FULL, `clipped`=1. Reset asserted with a request valid → `tokens`=0, no `accepted` pulse.
